mem_port_arbiter: RTL and testbench

Two-master arbiter sharing the single data port of `ram` between the CPU load/store path (master 0) and a secondary requester such as a program loader or debug port (master 1). It sits between the masters and `ram`, replacing the direct CPU-to-`ram` connection in `soc_top`. Each cycle it accepts at most one request, registers it onto the `ram` port, and routes the returned read data to the owning master with a valid strobe. Arbitration is round-robin by default.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of the single ram data port: combinational grant,
// registered issue, read data routed back to the owner two cycles after grant.
// Build option: ARB_FIXED_PRIO_EN makes master 0 win every contention.

module mem_port_lane #(
  parameter int IDX = 0,
  parameter int DW  = 32
) (
  input  logic          tag_vld,
  input  logic          tag_own,
  input  logic [DW-1:0] mem_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  assign rvalid = tag_vld && (tag_own == 1'(IDX));
  assign rdata  = mem_rdata;
endmodule

module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_cs,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int NUM_M  = 2;
  localparam int STAGES = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t [NUM_M-1:0]          req_bus;
  logic [NUM_M-1:0]          req_vec, gnt_vec, rvalid_vec;
  logic [NUM_M-1:0][DW-1:0]  rdata_vec;
  logic                      grant_any, sel, rd_issue;
  req_t                      sel_req;
  logic [STAGES:1]           vld_pipe, own_pipe;

  assign req_bus[0] = {m0_we, m0_addr, m0_wdata};
  assign req_bus[1] = {m1_we, m1_addr, m1_wdata};
  assign req_vec    = {m1_req, m0_req};

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vec = '0;
    if (rst) begin
      if (req_vec[0])      gnt_vec = 2'b01;
      else if (req_vec[1]) gnt_vec = 2'b10;
    end
  end
`else
  // last holds the index of the most recently granted master
  logic last;

  always_comb begin
    gnt_vec = '0;
    if (rst) begin
      unique case (req_vec)
        2'b01:   gnt_vec = 2'b01;
        2'b10:   gnt_vec = 2'b10;
        2'b11:   gnt_vec = last ? 2'b01 : 2'b10;
        default: gnt_vec = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           last <= 1'b1;
    else if (grant_any) last <= sel;
  end
`endif

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign grant_any = |gnt_vec;
  assign sel       = gnt_vec[1];
  assign sel_req   = req_bus[sel];
  assign rd_issue  = grant_any && !sel_req.we;

  // address/data deliberately hold across idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cs    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_cs <= grant_any;
      if (grant_any) begin
        mem_rw    <= sel_req.we;
        mem_addr  <= sel_req.addr;
        mem_wdata <= sel_req.wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_issue};
      own_pipe <= {own_pipe[STAGES-1:1], sel};
    end
  end

  for (genvar g = 0; g < NUM_M; g++) begin : g_lane
    mem_port_lane #(.IDX(g), .DW(DW)) u_lane (
      .tag_vld   (vld_pipe[STAGES]),
      .tag_own   (own_pipe[STAGES]),
      .mem_rdata (mem_rdata),
      .rvalid    (rvalid_vec[g]),
      .rdata     (rdata_vec[g])
    );
  end

  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];
  assign m0_rdata  = rdata_vec[0];
  assign m1_rdata  = rdata_vec[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: ram model, spec-level scoreboard monitor,
// directed scenarios followed by randomized two-master traffic.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_cs, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // synchronous ram: write at the edge, read data registered for next cycle
  logic [DW-1:0] ram [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_rw) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } iss_t;
  typedef struct { int cyc; int own; logic [DW-1:0] data; } rsp_t;
  iss_t          iq[$];
  rsp_t          rq[$];
  logic [DW-1:0] mdl [int unsigned];
  int            m_last = 1;

  // monitor: reference arbitration + memory contents, compared every cycle
  always @(negedge clk) begin
    iss_t ie;
    rsp_t re;
    logic e0, e1;
    int   w;
    if (!rst) begin
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_rvalid", m0_rvalid | m1_rvalid, 0);
      iq.delete();
      rq.delete();
      m_last = 1;
    end else begin
      if (mem_cs) begin
        if (iq.size() == 0) chk("mem_cs_spurious", mem_cs, 0);
        else begin
          ie = iq.pop_front();
          chk("issue_cycle", cyc, ie.cyc + 1);
          chk("mem_rw", mem_rw, ie.we);
          chk("mem_addr", mem_addr, ie.addr);
          if (ie.we) chk("mem_wdata", mem_wdata, ie.wdata);
        end
      end else if (iq.size() != 0 && iq[0].cyc + 1 <= cyc) begin
        ie = iq.pop_front();
        chk("mem_cs_missing", mem_cs, 1);
      end

      if (m0_rvalid && m1_rvalid) chk("rvalid_both", m0_rvalid & m1_rvalid, 0);
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0) chk("rvalid_spurious", m0_rvalid | m1_rvalid, 0);
        else begin
          re = rq.pop_front();
          chk("rvalid_cycle", cyc, re.cyc + 2);
          chk("rvalid_owner", m1_rvalid, re.own);
          chk("rdata", m1_rvalid ? m1_rdata : m0_rdata, re.data);
        end
      end else if (rq.size() != 0 && rq[0].cyc + 2 <= cyc) begin
        re = rq.pop_front();
        chk("rvalid_missing", m0_rvalid | m1_rvalid, 1);
      end

      e0 = 0;
      e1 = 0;
      if (m0_req && !m1_req)      e0 = 1;
      else if (!m0_req && m1_req) e1 = 1;
      else if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
        e0 = 1;
`else
        if (m_last == 1) e0 = 1; else e1 = 1;
`endif
      end
      chk("m0_gnt", m0_gnt, e0);
      chk("m1_gnt", m1_gnt, e1);

      if (e0 || e1) begin
        w = e1 ? 1 : 0;
        ie.cyc   = cyc;
        ie.we    = w ? m1_we : m0_we;
        ie.addr  = w ? m1_addr : m0_addr;
        ie.wdata = w ? m1_wdata : m0_wdata;
        iq.push_back(ie);
        if (ie.we) mdl[ie.addr] = ie.wdata;
        else begin
          re.cyc  = cyc;
          re.own  = w;
          re.data = mdl.exists(ie.addr) ? mdl[ie.addr] : '0;
          rq.push_back(re);
        end
        m_last = w;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic r, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic idle_all();
    m0_req = 0;
    m1_req = 0;
  endtask

  initial begin
    logic g0, g1, exp_m1;

    repeat (3) begin
      @(negedge clk);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_rw", mem_rw, 0);
    end
    next_cyc();
    rst = 1;

    // write 0xDEADBEEF to 0x10, then read it back
    drive(0, 1, 1, 'h10, 'hDEADBEEF);
    @(negedge clk); chk("t1_wr_gnt", m0_gnt, 1);
    next_cyc();
    drive(0, 1, 0, 'h10, '0);
    @(negedge clk);
    chk("t1_cs", mem_cs, 1); chk("t1_rw", mem_rw, 1); chk("t1_addr", mem_addr, 'h10);
    chk("t1_rd_gnt", m0_gnt, 1);
    next_cyc();
    idle_all();
    @(negedge clk); chk("t1_rd_cs", mem_cs, 1); chk("t1_rd_rw", mem_rw, 0);
    next_cyc();
    @(negedge clk);
    chk("t1_rvalid", m0_rvalid, 1); chk("t1_rdata", m0_rdata, 'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    next_cyc();

    // continuous contention: m0 was granted last, so m1 goes first
    drive(0, 1, 0, 'h20, '0);
    drive(1, 1, 0, 'h24, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
      exp_m1 = 1'b0;
`else
      exp_m1 = (i % 2 == 0);
`endif
      chk("t2_m1_gnt", m1_gnt, exp_m1);
      chk("t2_m0_gnt", m0_gnt, !exp_m1);
      next_cyc();
    end
    idle_all();
    repeat (3) next_cyc();

    // m1 writes, m0 reads the same address the next cycle
    drive(1, 1, 1, 'h30, 'h55);
    @(negedge clk); chk("t3_wr_gnt", m1_gnt, 1);
    next_cyc();
    idle_all();
    drive(0, 1, 0, 'h30, '0);
    @(negedge clk); chk("t3_rd_gnt", m0_gnt, 1);
    next_cyc();
    idle_all();
    @(negedge clk); chk("t3_early_rvalid", m0_rvalid | m1_rvalid, 0);
    next_cyc();
    @(negedge clk);
    chk("t3_rvalid", m0_rvalid, 1); chk("t3_rdata", m0_rdata, 'h55);
    chk("t3_m1_rvalid", m1_rvalid, 0);
    next_cyc();

    // reset in the cycle after a read grant
    drive(0, 1, 0, 'h10, '0);
    @(negedge clk); chk("t4_gnt", m0_gnt, 1);
    next_cyc();
    idle_all();
    chk("t4_cs_pre", mem_cs, 1);
    rst = 0;
    #1 chk("t4_cs_async", mem_cs, 0);
    repeat (2) next_cyc();
    rst = 1;
    repeat (4) begin
      @(negedge clk); chk("t4_no_rvalid", m0_rvalid | m1_rvalid, 0);
      next_cyc();
    end
    drive(0, 1, 0, 'h20, '0);
    drive(1, 1, 0, 'h24, '0);
    @(negedge clk); chk("t4_first_m0", m0_gnt, 1); chk("t4_first_m1", m1_gnt, 0);
    next_cyc();
    m0_req = 0;
    @(negedge clk); chk("t4_m1_after", m1_gnt, 1);
    next_cyc();
    idle_all();
    repeat (3) next_cyc();

`ifdef ARB_FIXED_PRIO_EN
    drive(0, 1, 0, 'h20, '0);
    drive(1, 1, 0, 'h24, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t5_m0_gnt", m0_gnt, 1); chk("t5_m1_gnt", m1_gnt, 0);
      next_cyc();
    end
    m0_req = 0;
    @(negedge clk); chk("t5_m1_gnt_drop", m1_gnt, 1);
    next_cyc();
    idle_all();
    repeat (3) next_cyc();
`endif

    // idle: port stays deselected and address holds
    drive(0, 1, 1, 'h44, 'h1234);
    @(negedge clk); chk("t6_gnt", m0_gnt, 1);
    next_cyc();
    idle_all();
    next_cyc();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_cs", mem_cs, 0);
      chk("t6_rvalid", m0_rvalid | m1_rvalid, 0);
      chk("t6_addr_hold", mem_addr, 'h44);
      next_cyc();
    end

    // random traffic; each master holds its request until granted
    for (int i = 0; i < 400; i++) begin
      if (!m0_req && $urandom_range(9) < 6)
        drive(0, 1, 1'($urandom_range(1)), AW'($urandom_range(15) * 4), $urandom);
      if (!m1_req && $urandom_range(9) < 6)
        drive(1, 1, 1'($urandom_range(1)), AW'($urandom_range(15) * 4), $urandom);
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      next_cyc();
      if (g0) m0_req = 0;
      if (g1) m1_req = 0;
    end
    idle_all();
    repeat (4) next_cyc();
    chk("drain_issue", iq.size(), 0);
    chk("drain_resp", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
